mod5_seq_checker: RTL

//  Downstream monitor for the 3-bit mod-5 up counter. Samples the counter value

---
 rtl/mod5_seq_checker.sv | 105 ++++++++++
 1 files changed

// File: rtl/mod5_seq_checker.sv
// Sequence monitor for a mod-5 up counter: checks 0-1-2-3-4-0 order, counts wraps,
// flags faults (pulse, sticky flag, saturating count) and re-locks on the next 0.
module mod5_seq_checker #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        cnt_in,
  input  logic              clr_err,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [2:0] prev;
  logic [2:0] prev_nxt;
  logic       tc_nxt;
  logic       fault;

  // Next-state logic. A sample of 0 is always accepted in TRACK (upstream
  // restart); only a 4->0 step counts as a wrap.
  always_comb begin
    nxt_state = cur_state;
    prev_nxt  = prev;
    tc_nxt    = 1'b0;
    fault     = 1'b0;
    if (en) begin
      case (cur_state)
        IDLE: begin
          if (cnt_in <= 3'd4) begin
            nxt_state = TRACK;
            prev_nxt  = cnt_in;
          end else begin
            fault = 1'b1;
          end
        end
        TRACK: begin
          if (cnt_in == 3'd0) begin
            prev_nxt = 3'd0;
            tc_nxt   = (prev == 3'd4);
          end else if ((prev < 3'd4) && (cnt_in == prev + 3'd1)) begin
            prev_nxt = cnt_in;
          end else begin
            fault = 1'b1;
          end
        end
        FAULT: begin
          if (cnt_in == 3'd0) begin
            nxt_state = TRACK;
            prev_nxt  = 3'd0;
          end
        end
        default: nxt_state = IDLE;
      endcase
      if (fault) nxt_state = FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      prev      <= 3'd0;
      tc_pulse  <= 1'b0;
      wrap_cnt  <= '0;
      seq_err   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      prev      <= prev_nxt;
      tc_pulse  <= tc_nxt;
      seq_err   <= fault;
      if (tc_nxt) wrap_cnt <= wrap_cnt + 1'b1;
    end
  end

  // A fault in the same cycle as clr_err wins: the count restarts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (fault) begin
      err_sticky <= 1'b1;
      if (clr_err)            err_cnt <= {{(ERR_W-1){1'b0}}, 1'b1};
      else if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end
  end

  assign state = cur_state;

endmodule
